// File: rtl/seq_div_32bits.sv
`default_nettype none
// ============================================================================
// seq_div_32bits : restoring unsigned divider, one quotient bit per clock,
//                  valid/ready handshake on operands and on the result.
// Revision 1.0
// ============================================================================
module seq_div_32bits #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int                 CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH+1:0]   ONE_W = {{(WIDTH+1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH+1:0] trial;
  logic             no_borrow;
  logic             unused_r_msb;

  // The partial remainder always stays below the divisor, so its MSB is
  // only ever zero between iterations and is shifted out unread.
  assign unused_r_msb = r_q[WIDTH];

  always_comb begin
    r_shift   = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    trial     = {1'b0, r_shift} + {1'b0, ~{1'b0, d_q}} + ONE_W;
    no_borrow = trial[WIDTH+1];

    state_d = state_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;

    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          d_d   = i_divisor;
          cnt_d = CNT_LOAD;
          if (i_divisor == '0) begin
            q_d     = '1;
            r_d     = {1'b0, i_dividend};
            quo_d   = '1;
            rem_d   = i_dividend;
            dz_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            q_d     = i_dividend;
            r_d     = '0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        r_d   = no_borrow ? trial[WIDTH:0] : r_shift;
        q_d   = {q_q[WIDTH-2:0], no_borrow};
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == '0) begin
          // Publish on the final iteration so DONE presents a settled result.
          quo_d   = q_d;
          rem_d   = r_d[WIDTH-1:0];
          dz_d    = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (i_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign o_ready       = (state_q == S_IDLE);
  assign o_valid       = (state_q == S_DONE);
  assign o_quotient    = quo_q;
  assign o_remainder   = rem_q;
  assign o_div_by_zero = dz_q;

endmodule
`default_nettype wire
